// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU execute-stage units:
// funct codes for the HI/LO instructions and the mul/div FSM state type.
package mips_cpu_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_negate.sv
// Conditional two's-complement: dout = en ? -din : din.
// Used to take operand magnitudes and to restore result signs.
module mips_cpu_muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Negation as subtraction from zero keeps operand widths equal.
  assign dout = en ? ({WIDTH{1'b0}} - din) : din;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiplier and restoring divider, one bit per cycle, with a
// start/busy/done handshake and a flush that abandons the operation.
// Optional macro MIPS_CPU_MULDIV_EARLY_EXIT_EN: multiplies stop iterating once
// the remaining multiplier bits are zero; the product is realigned in FIX.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo write HI/LO directly
// PREP  | take operand magnitudes, record result signs, load counter
// CALC  | one multiply or divide step per cycle
// FIX   | restore signs, commit HI/LO, pulse done
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t      state;
  logic               op_div;
  logic               op_signed;
  logic               neg_q;     // quotient / product sign
  logic               neg_r;     // remainder sign
  logic               div_zero;
  logic [WIDTH-1:0]   opa;       // multiplicand / dividend magnitude
  logic [WIDTH-1:0]   opb;       // multiplier (shifted) / divisor magnitude
  logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt;

  logic               is_muldiv;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic               calc_last;
  logic [2*WIDTH-1:0] prod_aligned;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign busy = (state != IDLE);

  assign is_muldiv = (opcode == FUNCT_MULT) || (opcode == FUNCT_MULTU) ||
                     (opcode == FUNCT_DIV)  || (opcode == FUNCT_DIVU);

  mips_cpu_muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en(op_signed & opa[WIDTH-1]), .din(opa), .dout(abs_a));
  mips_cpu_muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en(op_signed & opb[WIDTH-1]), .din(opb), .dout(abs_b));

  // One multiply step adds the multiplicand when the current multiplier bit
  // is set; one divide step trial-subtracts the divisor from the shifted
  // partial remainder.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (rem_shift >= {1'b0, opb});
  assign div_diff  = rem_shift[WIDTH-1:0] - opb;

`ifdef MIPS_CPU_MULDIV_EARLY_EXIT_EN
  // cnt is held on exit, so it equals the number of shifts still owed.
  assign calc_last    = (cnt == '0) || (!op_div && ((opb >> 1) == '0));
  assign prod_aligned = acc >> cnt;
`else
  assign calc_last    = (cnt == '0);
  assign prod_aligned = acc;
`endif

  mips_cpu_muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .en(neg_q), .din(prod_aligned), .dout(prod_fixed));
  mips_cpu_muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .en(neg_q), .din(acc[WIDTH-1:0]), .dout(quo_fixed));
  mips_cpu_muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en(neg_r), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fixed));

  // FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (opcode == FUNCT_MTHI) begin
                hi_reg <= a;
              end else if (opcode == FUNCT_MTLO) begin
                lo_reg <= a;
              end else if (is_muldiv) begin
                opa       <= a;
                opb       <= b;
                op_div    <= (opcode == FUNCT_DIV) || (opcode == FUNCT_DIVU);
                op_signed <= (opcode == FUNCT_MULT) || (opcode == FUNCT_DIV);
                state     <= PREP;
              end
            end
          end
          PREP: begin
            neg_q    <= op_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_r    <= op_signed & opa[WIDTH-1];
            div_zero <= (opb == '0);
            opa      <= abs_a;
            opb      <= abs_b;
            acc      <= op_div ? {{WIDTH{1'b0}}, abs_a} : '0;
            cnt      <= CNT_W'(WIDTH - 1);
            state    <= CALC;
          end
          CALC: begin
            if (op_div) begin
              acc <= div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                            : {acc[2*WIDTH-2:0], 1'b0};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
              opb <= opb >> 1;
            end
            if (calc_last) begin
              state <= FIX;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          FIX: begin
            if (op_div) begin
              lo_reg <= div_zero ? {WIDTH{1'b1}} : quo_fixed;
              hi_reg <= rem_fixed;
            end else begin
              {hi_reg, lo_reg} <= prod_fixed;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv (WIDTH = 32): table vectors plus
// random vectors through a result scoreboard, then hand-written sequences
// for mthi/mtlo, flush, undefined opcodes and mid-operation reset.
module tb_mips_cpu_muldiv;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi_reg(hi_reg), .lo_reg(lo_reg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        vt[13];
  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_count = 0;
  int          exp_done = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sp;
    logic [63:0]        up;
    longint             sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0;
    l = '0;
    if (op == FUNCT_MULT) begin
      sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      {h, l} = sp;
    end else if (op == FUNCT_MULTU) begin
      up = {32'b0, x} * {32'b0, y};
      {h, l} = up;
    end else if (y == 32'd0) begin
      l = 32'hFFFFFFFF;
      h = x;
    end else if (op == FUNCT_DIV) begin
      l = 32'(sx / sy);
      h = 32'(sx % sy);
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  function automatic int exp_lat(input logic [5:0] op, input logic [31:0] y);
    int lat;
    lat = 34;
`ifdef MIPS_CPU_MULDIV_EARLY_EXIT_EN
    if (op == FUNCT_MULT || op == FUNCT_MULTU) begin
      logic [31:0] m;
      int n;
      m = (op == FUNCT_MULT && y[31]) ? (32'd0 - y) : y;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      lat = n + 2;
    end
`endif
    return lat;
  endfunction

  // Called at a negedge; leaves at the negedge on which done is expected,
  // so a following call issues in the done cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
    int lat;
    bit win_ok;
    lat = exp_lat(op, y);
    start  = 1'b1;
    opcode = op;
    a      = x;
    b      = y;
    q.push_back('{hi: eh, lo: el});
    exp_done++;
    win_ok = 1'b1;
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (j < lat) begin
        if (!busy || done) win_ok = 1'b0;
      end else begin
        check("done_latency", {62'd0, busy, done}, 64'd1);
      end
    end
    check("busy_window", {63'd0, win_ok}, 64'd1);
  endtask

  // Scoreboard: each done pops the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      done_count++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: hi %h lo %h with no result pending", hi_reg, lo_reg);
      end else begin
        e = q.pop_front();
        check("hi", {32'd0, hi_reg}, {32'd0, e.hi});
        check("lo", {32'd0, lo_reg}, {32'd0, e.lo});
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
  end

  initial begin
    logic [31:0] eh, el, x, y;
    logic [5:0]  op;
    int          dc;

    vt[0]  = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[2]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{FUNCT_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vt[4]  = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5]  = '{FUNCT_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[6]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[7]  = '{FUNCT_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vt[8]  = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[9]  = '{FUNCT_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vt[10] = '{FUNCT_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vt[11] = '{FUNCT_MULTU, 32'h00000009, 32'h00000002, 32'h00000000, 32'h00000012};
    vt[12] = '{FUNCT_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    reset = 1'b0; start = 1'b0; flush = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_hilo",  {hi_reg, lo_reg}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: op = FUNCT_MULT;
        1: op = FUNCT_MULTU;
        2: op = FUNCT_DIV;
        default: op = FUNCT_DIVU;
      endcase
      x = $urandom();
      y = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300));
      model(op, x, y, eh, el);
      issue(op, x, y, eh, el);
    end

    // mthi is visible one cycle after start; flush in IDLE does not block it.
    start = 1'b1; opcode = FUNCT_MTHI; a = 32'h12345678; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("mthi_value", {32'd0, hi_reg}, 64'h12345678);
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    model_hi = 32'h12345678;

    start = 1'b1; opcode = FUNCT_MTLO; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_value", {32'd0, lo_reg}, 64'hCAFEF00D);
    model_lo = 32'hCAFEF00D;

    // Undefined opcode with start: ignored.
    start = 1'b1; opcode = 6'b100000; a = 32'h1; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("undef_busy", {63'd0, busy}, 64'd0);
    check("undef_hilo", {hi_reg, lo_reg}, {model_hi, model_lo});

    // Flush five cycles into a mult, with an mtlo request that must be ignored.
    dc = done_count;
    start = 1'b1; opcode = FUNCT_MULT; a = 32'h00001234; b = 32'h00005678;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1; opcode = FUNCT_MTLO; a = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle", {63'd0, busy}, 64'd0);
    check("flush_hilo", {hi_reg, lo_reg}, {model_hi, model_lo});
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_count), 64'(dc));
    check("flush_hilo_late", {hi_reg, lo_reg}, {model_hi, model_lo});

    // Asynchronous reset ten cycles into a divu.
    issue(FUNCT_MULTU, 32'h00010001, 32'h00010001, 32'h00000001, 32'h00020001);
    start = 1'b1; opcode = FUNCT_DIVU; a = 32'h00000100; b = 32'h00000003;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("rst_mid_hilo",  {hi_reg, lo_reg}, 64'd0);
    check("rst_mid_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(FUNCT_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    repeat (2) @(negedge clk);

    check("queue_empty", 64'(q.size()), 64'd0);
    check("done_count",  64'(done_count), 64'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Parametrised, multi-cycle multiply/divide unit holding the architectural HI/LO registers for the MIPS CPU. It replaces single-cycle `*`, `/` and `%` arithmetic with an iterative shift-add multiplier and a restoring divider. It adds an explicit start/busy/done handshake, a pipeline flush, and defined divide-by-zero results. It sits beside the ALU in the execute stage; the decode/control logic stalls `mfhi`/`mflo` while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `opcode` input 6: MIPS funct code: `010001` mthi, `010011` mtlo, `011000` mult, `011001` multu, `011010` div, `011011` divu. Other codes are no-ops.
- `a` input `WIDTH`: rs operand (multiplicand/dividend; mthi/mtlo source).
- `b` input `WIDTH`: rt operand (multiplier/divisor).
- `flush` input 1: cancel the in-flight operation.
- `busy` output 1: an operation is in progress.
- `done` output 1: one-cycle pulse when a mult/div result is committed.
- `hi_reg` output `WIDTH`: architectural HI.
- `lo_reg` output `WIDTH`: architectural LO.

## Operation
- Reset (asynchronous, `reset`=0):
  - state goes to IDLE;
  - `hi_reg`, `lo_reg`, `busy`, `done` all go to 0;
  - working registers are cleared.
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE:
  - `start` with mthi/mtlo: the target register loads `a` at that edge; the FSM stays in IDLE, and `busy`/`done` stay 0.
  - `start` with mult/multu/div/divu: operands are latched and the FSM goes to PREP.
  - `start` with an undefined opcode: ignored.
- PREP (1 cycle):
  - signed ops (mult, div): take operand magnitudes and record the result sign(s);
  - quotient sign = sign(a) XOR sign(b); remainder sign = sign(a);
  - product sign = sign(a) XOR sign(b);
  - the cycle counter loads `WIDTH`-1.
- CALC (`WIDTH` cycles, one bit per cycle):
  - multiply: shift-add into a 2·`WIDTH` product register;
  - divide: restoring step on a 2·`WIDTH` remainder/quotient register.
  - The FSM leaves CALC when the counter reaches 0.
- FIX (1 cycle): apply the sign correction, write `hi_reg`/`lo_reg`, pulse `done`, and return to IDLE.
- Results:
  - multiply: HI = upper `WIDTH` bits, LO = lower `WIDTH` bits of the exact 2·`WIDTH` product;
  - divide: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
- Divide by zero (both div and divu): LO = all ones, HI = `a`.
- Signed overflow (div of the most negative value by −1): LO = the most negative value, HI = 0. No exception is raised.
- `start` while busy: ignored, including mthi/mtlo. The issuing logic must hold the request until `busy`=0.
- `flush` while busy: the FSM returns to IDLE on the next edge, HI/LO stay unchanged, and `done` is not pulsed.
- `flush` in IDLE: no effect. It does not block a simultaneous `start`.
- `flush` in FIX: the commit is suppressed.

## Timing
- `start` for a mult/div is accepted at edge E0.
  - `busy`=1 from after E0 until after the FIX edge.
  - Results and `done` appear after edge E0+`WIDTH`+2 (34 cycles when `WIDTH`=32).
- `done` is high for exactly one cycle, during which `busy`=0. A new `start` in that cycle is accepted.
- mthi/mtlo: the register is visible one cycle after `start`.
- `hi_reg`/`lo_reg` hold their previous values for the whole operation; no partial results are ever visible.
- Reset asserted mid-operation aborts immediately; all outputs read 0.

## Configuration
- `MIPS_CPU_MULDIV_EARLY_EXIT_EN` defined:
  - multiplies leave CALC as soon as the remaining multiplier bits are all zero; the product register is aligned in FIX.
  - Latency is `n`+2 cycles, where `n` is the index of the highest set bit of the multiplier magnitude plus 1. A zero multiplier takes 3 cycles.
  - Division latency is unchanged.
- Macro undefined: fixed latency of `WIDTH`+2 for all mult/div ops.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the funct-code constants (`FUNCT_MTHI`, `FUNCT_MTLO`, `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`);
  - the `muldiv_state_t` enum (IDLE, PREP, CALC, FIX).
- One sub-module: `mips_cpu_muldiv_negate`, a `WIDTH`-parametrised conditional two's-complement used in PREP (for the operands) and in FIX (for the results).
- The counter is `$clog2(WIDTH)` bits wide.

## Test plan
1. Reset, then multu `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` 34 cycles after `start`; `busy` high throughout.
2. mult `a`=0xFFFFFFFD (−3), `b`=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. div `a`=0xFFFFFFF9 (−7), `b`=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. divu `a`=7, `b`=0 -> LO=0xFFFFFFFF, HI=7. div `a`=0x80000000, `b`=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. mthi 0x12345678 -> HI matches one cycle later. Then start a mult, and 5 cycles in pulse mtlo `start` plus `flush` -> mtlo ignored, FSM back in IDLE, HI/LO unchanged, no `done`.
5. Drop `reset` low 10 cycles into a divu -> HI/LO/`busy`/`done`=0 immediately. After release, a new multu 3×4 -> LO=12, HI=0.
6. With `MIPS_CPU_MULDIV_EARLY_EXIT_EN`: multu `a`=9, `b`=2 -> LO=18, `done` 4 cycles after `start`. `b`=0 -> LO=0, HI=0, `done` 3 cycles after `start`.
